// File: rtl/idct_pkg.sv
// Shared types, cosine coefficient tables and the pixel clip helper for the IDCT pass engine.
package idct_pkg;

    typedef enum logic {
        T_PASS = 1'b0,
        S_PASS = 1'b1
    } pass_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LWAIT = 3'd2,
        ST_MAC   = 3'd3,
        ST_DONE  = 3'd4
    } idct_state_t;

    // C[k][j] = round(4096*sqrt((k==0?1:2)/N)*cos((2j+1)k*pi/(2N))), row-major by k.
    localparam logic signed [15:0] COEF8 [64] = '{
        16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,
        16'sd2009,  16'sd1703,  16'sd1138,  16'sd400,  -16'sd400,  -16'sd1138, -16'sd1703, -16'sd2009,
        16'sd1892,  16'sd784,  -16'sd784,  -16'sd1892, -16'sd1892, -16'sd784,   16'sd784,   16'sd1892,
        16'sd1703, -16'sd400,  -16'sd2009, -16'sd1138,  16'sd1138,  16'sd2009,  16'sd400,  -16'sd1703,
        16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,
        16'sd1138, -16'sd2009,  16'sd400,   16'sd1703, -16'sd1703, -16'sd400,   16'sd2009, -16'sd1138,
        16'sd784,  -16'sd1892,  16'sd1892, -16'sd784,  -16'sd784,   16'sd1892, -16'sd1892,  16'sd784,
        16'sd400,  -16'sd1138,  16'sd1703, -16'sd2009,  16'sd2009, -16'sd1703,  16'sd1138, -16'sd400
    };

    localparam logic signed [15:0] COEF4 [16] = '{
        16'sd2048,  16'sd2048,  16'sd2048,  16'sd2048,
        16'sd2676,  16'sd1108, -16'sd1108, -16'sd2676,
        16'sd2048, -16'sd2048, -16'sd2048,  16'sd2048,
        16'sd1108, -16'sd2676,  16'sd2676, -16'sd1108
    };

    // Table lookup; for N=4 only the low two bits of k and j are meaningful.
    function automatic logic signed [15:0] coef_lookup(input logic is_n8,
                                                       input logic [2:0] k,
                                                       input logic [2:0] j);
        if (is_n8) return COEF8[{k, j}];
        else       return COEF4[{k[1:0], j[1:0]}];
    endfunction

    // Saturate a signed value into the 0..255 pixel range.
    function automatic logic [7:0] clip_u8(input logic signed [63:0] v);
        if (v < 64'sd0)        return 8'd0;
        else if (v > 64'sd255) return 8'd255;
        else                   return v[7:0];
    endfunction

endpackage

// File: rtl/idct_pass_engine_if.sv
// Bus bundle between the top controller / embedded RAMs and the IDCT pass engine.
//
// Handshake: the controller raises start (with mode, src_base, dst_base stable) for
// at least one cycle while busy is low; the engine accepts on that edge, raises busy,
// and ignores start until it returns to idle. done pulses for exactly one cycle at the
// end of a completed pass; busy drops on the cycle after done. Source reads return
// data one cycle after the address; each wr_en cycle is one destination write.
interface idct_pass_engine_if
    import idct_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int IN_W   = 32,
    parameter int OUT_W  = 32
) ();
    logic              start;
    pass_mode_t        mode;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [IN_W-1:0]   rd_data_a;
    logic [IN_W-1:0]   rd_data_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [OUT_W-1:0]  wr_data;
    logic              wr_en;

    modport slave (
        input  start, mode, src_base, dst_base, rd_data_a, rd_data_b,
        output busy, done, rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en
    );

    modport master (
        output start, mode, src_base, dst_base, rd_data_a, rd_data_b,
        input  busy, done, rd_addr_a, rd_addr_b, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/idct_coef_rom.sv
// Combinational dual-read cosine coefficient lookup: (k0,j0)->c0, (k1,j1)->c1.
// Both passes consume C[k][inner], so the S-pass transpose is just the caller's
// choice of which loop index drives the j inputs.
module idct_coef_rom
    import idct_pkg::*;
#(
    parameter int N      = 8,
    parameter int COEF_W = 16
) (
    input  logic [$clog2(N)-1:0] k0,
    input  logic [$clog2(N)-1:0] j0,
    input  logic [$clog2(N)-1:0] k1,
    input  logic [$clog2(N)-1:0] j1,
    output logic signed [COEF_W-1:0] c0,
    output logic signed [COEF_W-1:0] c1
);

    // Two independent table reads, sign-extended to the coefficient width.
    always_comb begin
        c0 = COEF_W'(coef_lookup(N == 8, 3'(k0), 3'(j0)));
        c1 = COEF_W'(coef_lookup(N == 8, 3'(k1), 3'(j1)));
    end

endmodule

// File: rtl/idct_pass_engine.sv
// One IDCT matrix pass: T = A x C (mode 0) or S = C^T x A with pixel clip (mode 1).
// A row (mode 0) or column (mode 1) of A is buffered, then every output element of
// that row/column is produced with two multipliers over N/2 beats.
module idct_pass_engine
    import idct_pkg::*;
#(
    parameter int N      = 8,
    parameter int IN_W   = 32,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 7,
    parameter int SHIFT0 = 8,
    parameter int SHIFT1 = 16
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    idct_pass_engine_if.slave        bus,
    output idct_state_t              dbg_state
);

    localparam int IDX_W  = $clog2(N);
    localparam int MW     = IDX_W - 1;
    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = IN_W + COEF_W + IDX_W;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
    localparam logic [MW-1:0]     BEAT_LAST = MW'(N / 2 - 1);
    localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);

    idct_state_t              state_q, state_d;
    pass_mode_t               mode_q, mode_d;
    logic [ADDR_W-1:0]        src_q, src_d;
    logic [ADDR_W-1:0]        dst_q, dst_d;
    logic [IDX_W-1:0]         outer_q, outer_d;
    logic [IDX_W-1:0]         inner_q, inner_d;
    logic [MW-1:0]            beat_q, beat_d;
    logic                     cap_q, cap_d;
    logic [MW-1:0]            cap_beat_q, cap_beat_d;
    logic signed [IN_W-1:0]   vec_q [N];
    logic signed [IN_W-1:0]   vec_d [N];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [OUT_W-1:0]         wr_data_q, wr_data_d;

    logic signed [COEF_W-1:0] coef0, coef1;
    logic signed [PROD_W-1:0] prod0, prod1;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  scaled0, scaled1;
    logic [ADDR_W-1:0]        rd_a, rd_b;
    logic [ADDR_W-1:0]        outer_a, inner_a, beat2_a;

    assign outer_a = ADDR_W'(outer_q);
    assign inner_a = ADDR_W'(inner_q);
    assign beat2_a = ADDR_W'({beat_q, 1'b0});

    idct_coef_rom #(
        .N      (N),
        .COEF_W (COEF_W)
    ) u_coef_rom (
        .k0 ({beat_q, 1'b0}),
        .j0 (inner_q),
        .k1 ({beat_q, 1'b1}),
        .j1 (inner_q),
        .c0 (coef0),
        .c1 (coef1)
    );

    // MAC datapath: two products per beat folded into the running accumulator.
    always_comb begin
        prod0   = PROD_W'(vec_q[{beat_q, 1'b0}]) * PROD_W'(coef0);
        prod1   = PROD_W'(vec_q[{beat_q, 1'b1}]) * PROD_W'(coef1);
        sum     = acc_q + ACC_W'(prod0) + ACC_W'(prod1);
        scaled0 = sum >>> SHIFT0;
        scaled1 = sum >>> SHIFT1;
    end

    // Buffer capture: a read pair issued in LOAD lands one cycle later.
    always_comb begin
        vec_d = vec_q;
        if (cap_q) begin
            vec_d[{cap_beat_q, 1'b0}] = bus.rd_data_a;
            vec_d[{cap_beat_q, 1'b1}] = bus.rd_data_b;
        end
    end

    // FSM next state, loop counters, read addresses and write-result staging.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        src_d      = src_q;
        dst_d      = dst_q;
        outer_d    = outer_q;
        inner_d    = inner_q;
        beat_d     = beat_q;
        cap_d      = 1'b0;
        cap_beat_d = beat_q;
        acc_d      = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_a       = '0;
        rd_b       = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    mode_d  = bus.mode;
                    src_d   = bus.src_base;
                    dst_d   = bus.dst_base;
                    outer_d = '0;
                    inner_d = '0;
                    beat_d  = '0;
                end
            end
            ST_LOAD: begin
                if (mode_q == T_PASS) begin
                    rd_a = src_q + outer_a * N_A + beat2_a;
                    rd_b = rd_a + ADDR_W'(1);
                end else begin
                    rd_a = src_q + beat2_a * N_A + outer_a;
                    rd_b = rd_a + N_A;
                end
                cap_d      = 1'b1;
                cap_beat_d = beat_q;
                if (beat_q == BEAT_LAST) begin
                    beat_d  = '0;
                    state_d = ST_LWAIT;
                end else begin
                    beat_d = beat_q + MW'(1);
                end
            end
            ST_LWAIT: begin
                state_d = ST_MAC;
            end
            ST_MAC: begin
                if (beat_q == BEAT_LAST) begin
                    // Element complete: stage the write; accumulator restarts at zero.
                    wr_en_d = 1'b1;
                    if (mode_q == T_PASS) begin
                        wr_addr_d = dst_q + outer_a * N_A + inner_a;
                        wr_data_d = OUT_W'(scaled0);
                    end else begin
                        wr_addr_d = dst_q + inner_a * N_A + outer_a;
                        wr_data_d = OUT_W'(clip_u8(64'(scaled1)));
                    end
                    beat_d = '0;
                    if (inner_q == IDX_LAST) begin
                        inner_d = '0;
                        if (outer_q == IDX_LAST) begin
                            outer_d = '0;
                            state_d = ST_DONE;
                        end else begin
                            outer_d = outer_q + IDX_W'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        inner_d = inner_q + IDX_W'(1);
                    end
                end else begin
                    acc_d  = sum;
                    beat_d = beat_q + MW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any pass in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            mode_q     <= T_PASS;
            src_q      <= '0;
            dst_q      <= '0;
            outer_q    <= '0;
            inner_q    <= '0;
            beat_q     <= '0;
            cap_q      <= 1'b0;
            cap_beat_q <= '0;
            acc_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int n = 0; n < N; n++) vec_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            outer_q    <= outer_d;
            inner_q    <= inner_d;
            beat_q     <= beat_d;
            cap_q      <= cap_d;
            cap_beat_q <= cap_beat_d;
            acc_q      <= acc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            vec_q      <= vec_d;
        end
    end

    assign bus.rd_addr_a = rd_a;
    assign bus.rd_addr_b = rd_b;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_idct_pass_engine.sv
// Directed bench for idct_pass_engine (N=8): source RAM model, write monitor, per-feature tasks.
module tb_idct_pass_engine;
    import idct_pkg::*;

    localparam int N      = 8;
    localparam int IN_W   = 32;
    localparam int OUT_W  = 32;
    localparam int ADDR_W = 7;
    localparam int W      = ADDR_W + OUT_W;
    localparam int LAT    = 297;

    logic        Clock;
    logic        Resetn;
    idct_state_t dbg_state;

    idct_pass_engine_if #(.ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    idct_pass_engine #(
        .N(N), .IN_W(IN_W), .COEF_W(16), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SHIFT0(8), .SHIFT1(16)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int lat;

    logic [IN_W-1:0] src_mem [128];
    logic [W-1:0]    exp_q[$];
    logic [W-1:0]    got_q[$];

    // Clock and watchdog
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Source RAM: one-cycle read latency on both ports
    always @(posedge Clock) begin
        bus.rd_data_a <= src_mem[bus.rd_addr_a];
        bus.rd_data_b <= src_mem[bus.rd_addr_b];
    end

    // Destination monitor, sampled on the falling edge
    always @(negedge Clock) begin
        if (bus.wr_en === 1'b1) got_q.push_back({bus.wr_addr, bus.wr_data});
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic clear_src();
        for (int a = 0; a < 128; a++) src_mem[a] = '0;
    endtask

    task automatic fill_row0(input logic [ADDR_W-1:0] base, input logic [IN_W-1:0] v);
        clear_src();
        for (int c = 0; c < N; c++) src_mem[base + ADDR_W'(c)] = v;
    endtask

    // Expected write stream: T_PASS row-major, S_PASS column-major; value by output row.
    task automatic build_exp(input pass_mode_t m, input logic [ADDR_W-1:0] dst,
                             input logic [OUT_W-1:0] v_row0, input logic [OUT_W-1:0] v_rest);
        int i, j;
        exp_q.delete();
        for (int o = 0; o < N; o++) begin
            for (int e = 0; e < N; e++) begin
                if (m == T_PASS) begin i = o; j = e; end
                else begin i = e; j = o; end
                exp_q.push_back({dst + ADDR_W'(i * N + j), (i == 0) ? v_row0 : v_rest});
            end
        end
    endtask

    // Driver: start a pass, optionally re-pulse start at cycle 'inject', wait for done.
    task automatic run_pass(input pass_mode_t m, input logic [ADDR_W-1:0] src,
                            input logic [ADDR_W-1:0] dst, input int inject, output int l);
        got_q.delete();
        @(negedge Clock);
        bus.start = 1'b1; bus.mode = m; bus.src_base = src; bus.dst_base = dst;
        l = -1;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(posedge Clock); #1;
            bus.start = (cyc == inject);
            if (cyc == inject) begin
                bus.mode = (m == T_PASS) ? S_PASS : T_PASS;
                bus.dst_base = dst + ADDR_W'(64);
            end
            if (bus.done === 1'b1) begin
                l = cyc;
                break;
            end
        end
        bus.start = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        bus.start = 1'b0; bus.mode = T_PASS; bus.src_base = '0; bus.dst_base = '0;
        clear_src();
        repeat (3) @(negedge Clock);
        tests_run++;
        if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy/done/wr_en=%b required 000", {bus.busy, bus.done, bus.wr_en});
        end
        tests_run++;
        if ({bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr, bus.wr_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: rd_a=%0d rd_b=%0d wr_addr=%0d wr_data=%0h required all 0",
                     bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr, bus.wr_data);
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, ST_IDLE);
        end
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_zero_pass();
        clear_src();
        build_exp(T_PASS, 7'd64, 32'd0, 32'd0);
        done_cnt = 0;
        run_pass(T_PASS, 7'd0, 7'd64, 0, lat);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL zero_latency: got %0d cycles (-1 = timeout) required %0d", lat, LAT);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL zero_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            tests_run++;
            if (got_q[n] !== exp_q[n]) begin
                tests_failed++;
                $display("FAIL zero_write[%0d]: got addr/data %h required %h", n, got_q[n], exp_q[n]);
            end
        end
    endtask

    task automatic test_t_pass_impulse();
        clear_src();
        src_mem[0] = 32'd256;
        build_exp(T_PASS, 7'd0, 32'd1448, 32'd0);
        run_pass(T_PASS, 7'd0, 7'd0, 0, lat);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL tpass_latency: got %0d cycles required %0d", lat, LAT);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL tpass_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            tests_run++;
            if (got_q[n] !== exp_q[n]) begin
                tests_failed++;
                $display("FAIL tpass_write[%0d]: got addr/data %h required %h", n, got_q[n], exp_q[n]);
            end
        end
    endtask

    task automatic test_s_pass_dc();
        fill_row0(7'd0, 32'd5792);
        build_exp(S_PASS, 7'd0, 32'd127, 32'd127);
        run_pass(S_PASS, 7'd0, 7'd0, 0, lat);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL spass_latency: got %0d cycles required %0d", lat, LAT);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL spass_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            tests_run++;
            if (got_q[n] !== exp_q[n]) begin
                tests_failed++;
                $display("FAIL spass_write[%0d]: got addr/data %h required %h", n, got_q[n], exp_q[n]);
            end
        end
    endtask

    // Clip in both directions; the 255 run uses dst_base 100 so addresses wrap past 127.
    task automatic test_s_pass_clip();
        logic [IN_W-1:0]   vin [2];
        logic [OUT_W-1:0]  vexp [2];
        logic [ADDR_W-1:0] dsts [2];
        vin[0] = -32'sd5792; vexp[0] = 32'd0;   dsts[0] = 7'd0;
        vin[1] = 32'd20000;  vexp[1] = 32'd255; dsts[1] = 7'd100;
        for (int t = 0; t < 2; t++) begin
            fill_row0(7'd0, vin[t]);
            build_exp(S_PASS, dsts[t], vexp[t], vexp[t]);
            run_pass(S_PASS, 7'd0, dsts[t], 0, lat);
            tests_run++;
            if (got_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL clip%0d_count: got %0d writes required %0d", t, got_q.size(), exp_q.size());
            end
            for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
                tests_run++;
                if (got_q[n] !== exp_q[n]) begin
                    tests_failed++;
                    $display("FAIL clip%0d_write[%0d]: got addr/data %h required %h", t, n, got_q[n], exp_q[n]);
                end
            end
        end
    endtask

    // First two LOAD beats at src_base 64 in both modes.
    task automatic test_addresses();
        pass_mode_t        modes [2];
        logic [ADDR_W-1:0] exp_a [2][2];
        logic [ADDR_W-1:0] exp_b [2][2];
        modes[0] = S_PASS; exp_a[0][0] = 7'd64; exp_b[0][0] = 7'd72; exp_a[0][1] = 7'd80; exp_b[0][1] = 7'd88;
        modes[1] = T_PASS; exp_a[1][0] = 7'd64; exp_b[1][0] = 7'd65; exp_a[1][1] = 7'd66; exp_b[1][1] = 7'd67;
        clear_src();
        for (int t = 0; t < 2; t++) begin
            @(negedge Clock);
            bus.start = 1'b1; bus.mode = modes[t]; bus.src_base = 7'd64; bus.dst_base = 7'd0;
            for (int b = 0; b < 2; b++) begin
                @(posedge Clock); #1;
                bus.start = 1'b0;
                tests_run++;
                if (bus.rd_addr_a !== exp_a[t][b] || bus.rd_addr_b !== exp_b[t][b]) begin
                    tests_failed++;
                    $display("FAIL addr_mode%0d_beat%0d: got a=%0d b=%0d required a=%0d b=%0d",
                             modes[t], b, bus.rd_addr_a, bus.rd_addr_b, exp_a[t][b], exp_b[t][b]);
                end
            end
            lat = -1;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                @(posedge Clock); #1;
                if (bus.done === 1'b1) begin lat = cyc; break; end
            end
            tests_run++;
            if (lat < 0) begin
                tests_failed++;
                $display("FAIL addr_mode%0d_done: got timeout required done", modes[t]);
            end
            repeat (2) @(negedge Clock);
        end
    endtask

    // A second start (opposite mode, other dst) while busy must change nothing.
    task automatic test_start_ignored();
        clear_src();
        src_mem[0] = 32'd256;
        build_exp(T_PASS, 7'd0, 32'd1448, 32'd0);
        done_cnt = 0;
        run_pass(T_PASS, 7'd0, 7'd0, 50, lat);
        repeat (320) @(negedge Clock);
        tests_run++;
        if (lat !== LAT) begin
            tests_failed++;
            $display("FAIL ignore_latency: got %0d cycles required %0d", lat, LAT);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL ignore_done_count: got %0d done pulses required 1", done_cnt);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL ignore_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            tests_run++;
            if (got_q[n] !== exp_q[n]) begin
                tests_failed++;
                $display("FAIL ignore_write[%0d]: got addr/data %h required %h", n, got_q[n], exp_q[n]);
            end
        end
    endtask

    // Reset at cycle 100 aborts the pass; a restart then produces the impulse result.
    task automatic test_reset_abort();
        clear_src();
        src_mem[0] = 32'd256;
        done_cnt = 0;
        @(negedge Clock);
        bus.start = 1'b1; bus.mode = T_PASS; bus.src_base = 7'd0; bus.dst_base = 7'd0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge Clock); #1;
            bus.start = 1'b0;
        end
        Resetn = 1'b0;
        @(negedge Clock);
        tests_run++;
        if ({bus.wr_en, bus.busy, bus.done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_outputs: wr_en/busy/done=%b required 000", {bus.wr_en, bus.busy, bus.done});
        end
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        repeat (5) @(negedge Clock);
        tests_run++;
        if (done_cnt != 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done_cnt=%0d busy=%b required 0 and 0", done_cnt, bus.busy);
        end
        build_exp(T_PASS, 7'd0, 32'd1448, 32'd0);
        run_pass(T_PASS, 7'd0, 7'd0, 0, lat);
        tests_run++;
        if (lat !== LAT || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL restart_done: got latency %0d done_cnt %0d required %0d and 1", lat, done_cnt, LAT);
        end
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL restart_count: got %0d writes required %0d", got_q.size(), exp_q.size());
        end
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            tests_run++;
            if (got_q[n] !== exp_q[n]) begin
                tests_failed++;
                $display("FAIL restart_write[%0d]: got addr/data %h required %h", n, got_q[n], exp_q[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_pass();
        test_t_pass_impulse();
        test_s_pass_dc();
        test_s_pass_clip();
        test_addresses();
        test_start_ignored();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
